// File: rtl/mpu_pkg.sv
// Shared definitions for the int8 matrix unit: feeder state encoding and
// the default geometry used by the buffers, the feeder and the array.
package mpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } feeder_state_t;

  localparam int MPU_LANES = 8;
  localparam int MPU_DSIZE = 8;
  localparam int MPU_LSIZE = 8;

endpackage

// File: rtl/skew_lane_mask.sv
// Diagonal lane-activity mask: lane i is live for len cycles starting at cyc==i.
// Bounds are formed at CW bits so i+len never wraps.
module skew_lane_mask #(
  parameter int LANES = 8,
  parameter int LSIZE = 8,
  parameter int CW    = LSIZE + 4
) (
  input  logic             run_i,
  input  logic [CW-1:0]    cyc_i,
  input  logic [LSIZE-1:0] len_i,
  output logic [LANES-1:0] active_o
);

  logic [CW-1:0] lane_lo;
  logic [CW-1:0] lane_hi;

  // Per-lane window test [i, i+len) on the shared wavefront counter.
  always_comb begin
    active_o = '0;
    lane_lo  = '0;
    lane_hi  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_lo     = CW'(i);
      lane_hi     = CW'(i) + CW'(len_i);
      active_o[i] = run_i && (cyc_i >= lane_lo) && (cyc_i < lane_hi);
    end
  end

endmodule

// File: rtl/skew_feeder.sv
// Read-side skew controller: pops the per-row buffers on a diagonal and
// presents registered, aligned operand wavefronts to the array edge. Any
// empty active lane freezes the whole wavefront so skew is never disturbed.
//
// state | meaning
// IDLE  | waiting for start; len==0 requests complete immediately
// RUN   | draining lanes; cyc advances only on unstalled cycles
module skew_feeder
  import mpu_pkg::*;
#(
  parameter int LANES = MPU_LANES,
  parameter int DSIZE = MPU_DSIZE,
  parameter int LSIZE = MPU_LSIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LSIZE-1:0]       len,
  output logic                   busy,
  output logic                   done,
  input  logic [LANES-1:0]       fifo_empty,
  input  logic [LANES*DSIZE-1:0] fifo_dout,
  output logic [LANES-1:0]       fifo_ren,
  output logic [LANES*DSIZE-1:0] arr_data,
  output logic [LANES-1:0]       arr_lane_valid,
  output logic                   arr_en
);

  // Counter spans len+LANES-2, so leave headroom for the lane offset.
  localparam int CW = LSIZE + $clog2(LANES) + 1;

  feeder_state_t          state_q;
  logic [CW-1:0]          cyc_q;
  logic [CW-1:0]          cyc_d;
  logic [LSIZE-1:0]       len_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   arr_en_q;
  logic [LANES-1:0]       arr_valid_q;
  logic [LANES*DSIZE-1:0] arr_data_q;
  logic [LANES*DSIZE-1:0] arr_data_d;

  logic                   run;
  logic [LANES-1:0]       active;
  logic                   stall;
  logic                   last;

  assign run = (state_q == RUN);

  skew_lane_mask #(
    .LANES (LANES),
    .LSIZE (LSIZE),
    .CW    (CW)
  ) u_mask (
    .run_i    (run),
    .cyc_i    (cyc_q),
    .len_i    (len_q),
    .active_o (active)
  );

  // Pop strobes: all active lanes move together, none while reset is held.
  always_comb begin
    stall    = |(active & fifo_empty);
    fifo_ren = rst ? (active & ~{LANES{stall}}) : '0;
    cyc_d    = cyc_q + CW'(1);
    last     = run && !stall && (cyc_q == CW'(len_q) + CW'(LANES - 2));
  end

  // Operand capture: popped lanes forward their head word, idle lanes send zero.
  always_comb begin
    arr_data_d = '0;
    for (int i = 0; i < LANES; i++) begin
      arr_data_d[i*DSIZE +: DSIZE] = fifo_ren[i] ? fifo_dout[i*DSIZE +: DSIZE] : '0;
    end
  end

  // Sequencer, wavefront counter and registered array-side outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arr_en_q    <= 1'b0;
      arr_valid_q <= '0;
      arr_data_q  <= '0;
    end else begin
      done_q      <= 1'b0;
      arr_en_q    <= run && !stall;
      arr_valid_q <= fifo_ren;
      arr_data_q  <= arr_data_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              len_q   <= len;
              cyc_q   <= '0;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!stall) begin
            cyc_q <= cyc_d;
            if (last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign arr_en         = arr_en_q;
  assign arr_lane_valid = arr_valid_q;
  assign arr_data       = arr_data_q;

endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder with four lanes. Lane buffers are modelled as
// first-word-fall-through arrays; the reference tracks each transfer as a
// sequence of wavefronts indexed by the number of unstalled cycles.
module tb_skew_feeder;

  localparam int LANES = 4;
  localparam int DSIZE = 8;
  localparam int LSIZE = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [LSIZE-1:0]       len;
  logic                   busy;
  logic                   done;
  logic [LANES-1:0]       fifo_empty;
  logic [LANES*DSIZE-1:0] fifo_dout;
  logic [LANES-1:0]       fifo_ren;
  logic [LANES*DSIZE-1:0] arr_data;
  logic [LANES-1:0]       arr_lane_valid;
  logic                   arr_en;

  logic [DSIZE-1:0] mem [LANES][512];
  int               wr_cnt [LANES];
  int               rd_ptr [LANES];
  logic [LANES-1:0] hold;
  logic [DSIZE-1:0] exp_d [LANES][16];
  bit               rnd_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  skew_feeder #(.LANES(LANES), .DSIZE(DSIZE), .LSIZE(LSIZE)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .len            (len),
    .busy           (busy),
    .done           (done),
    .fifo_empty     (fifo_empty),
    .fifo_dout      (fifo_dout),
    .fifo_ren       (fifo_ren),
    .arr_data       (arr_data),
    .arr_lane_valid (arr_lane_valid),
    .arr_en         (arr_en)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_fifo
    assign fifo_empty[g]              = hold[g] || (rd_ptr[g] == wr_cnt[g]);
    assign fifo_dout[g*DSIZE +: DSIZE] = mem[g][rd_ptr[g] & 511];
  end

  always @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (fifo_ren[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loads L words per lane and raises start for the next edge.
  task automatic launch(input int L);
    logic [DSIZE-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < L; j++) begin
        v = rnd_data ? DSIZE'($urandom) : DSIZE'(i * 16 + j);
        mem[i][wr_cnt[i] & 511] = v;
        exp_d[i][j] = v;
        wr_cnt[i]++;
      end
    end
    start = 1'b1;
    len   = LSIZE'(L);
  endtask

  // Follows one launched transfer to its done pulse. st_lane is held empty
  // for the first st_until cycles; ign_k injects a len=7 start mid-run;
  // next_l launches a follow-on transfer in the done cycle.
  task automatic run_xfer(input int L, input int st_lane, input int st_until,
                          input int ign_k, input int next_l);
    int               u, k, pu;
    int               pops0 [LANES];
    int               mp [LANES];
    bit               in_run, prev_pop, fin, stl, last_w;
    logic [LANES-1:0] act, emp, exp_valid;
    logic [LANES*DSIZE-1:0] exp_data;
    for (int i = 0; i < LANES; i++) begin
      pops0[i] = rd_ptr[i];
      mp[i]    = 0;
    end
    u = 0; k = 0; pu = 0;
    in_run = 1'b1; prev_pop = 1'b0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == ign_k) begin
        start = 1'b1;
        len   = 8'd7;
      end else if (k == ign_k + 1) begin
        start = 1'b0;
      end
      hold = (st_lane >= 0 && k < st_until) ? LANES'(1 << st_lane) : '0;
      #1;
      exp_valid = '0;
      exp_data  = '0;
      if (prev_pop) begin
        for (int i = 0; i < LANES; i++) begin
          if (pu >= i && pu < i + L) begin
            exp_valid[i] = 1'b1;
            exp_data[i*DSIZE +: DSIZE] = exp_d[i][pu - i];
          end
        end
      end
      last_w = prev_pop && (pu == L + LANES - 2);
      check("arr_en", 64'(arr_en), 64'(prev_pop));
      check("arr_lane_valid", 64'(arr_lane_valid), 64'(exp_valid));
      check("arr_data", 64'(arr_data), 64'(exp_data));
      check("done", 64'(done), 64'(last_w));
      check("busy", 64'(busy), 64'(in_run));
      act = '0;
      emp = '0;
      for (int i = 0; i < LANES; i++) begin
        act[i] = in_run && (u >= i) && (u < i + L);
        emp[i] = hold[i] || (mp[i] >= L);
      end
      stl = |(act & emp);
      check("fifo_ren", 64'(fifo_ren), stl ? 64'(0) : 64'(act));
      prev_pop = in_run && !stl;
      pu = u;
      if (in_run && !stl) begin
        for (int i = 0; i < LANES; i++) if (act[i]) mp[i]++;
        if (u == L + LANES - 2) in_run = 1'b0;
        u++;
      end
      if (last_w) begin
        fin = 1'b1;
        for (int i = 0; i < LANES; i++) check("pops_per_lane", 64'(rd_ptr[i] - pops0[i]), 64'(L));
        if (next_l != 0) launch(next_l);
      end
      k++;
      if (!fin && k > 300) begin
        check("timeout_waiting_done", 64'(0), 64'(1));
        fin = 1'b1;
      end
    end
    hold = '0;
  endtask

  initial begin
    int L, sl, su;
    rst = 1'b0; start = 1'b0; len = '0; hold = '0; rnd_data = 1'b0;
    for (int i = 0; i < LANES; i++) wr_cnt[i] = 0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_arr_en", 64'(arr_en), 64'(0));
    check("rst_valid", 64'(arr_lane_valid), 64'(0));
    check("rst_data", 64'(arr_data), 64'(0));
    check("rst_ren", 64'(fifo_ren), 64'(0));
    rst = 1'b1;

    // Preloaded, no stall
    @(negedge clk);
    launch(3);
    run_xfer(3, -1, 0, -1, 0);

    // Lane 2 empty for the first five cycles
    launch(3);
    run_xfer(3, 2, 5, -1, 0);

    // len == 0
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("len0_done", 64'(done), 64'(1));
    check("len0_busy", 64'(busy), 64'(0));
    check("len0_ren", 64'(fifo_ren), 64'(0));
    @(negedge clk);
    #1;
    check("len0_done_clr", 64'(done), 64'(0));
    check("len0_busy2", 64'(busy), 64'(0));
    check("len0_ren2", 64'(fifo_ren), 64'(0));

    // start with len=7 while busy must be ignored
    launch(3);
    run_xfer(3, -1, 0, 2, 0);

    // Reset at cyc==2
    launch(3);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ren", 64'(fifo_ren), 64'(0));
    @(negedge clk);
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_arr_en", 64'(arr_en), 64'(0));
    check("mid_rst_valid", 64'(arr_lane_valid), 64'(0));
    check("mid_rst_data", 64'(arr_data), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_done", 64'(done), 64'(0));
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_arr_en", 64'(arr_en), 64'(0));
    for (int i = 0; i < LANES; i++) wr_cnt[i] = rd_ptr[i];
    launch(3);
    run_xfer(3, -1, 0, -1, 0);

    // Back-to-back: 3 then 2 with start in the done cycle
    launch(3);
    run_xfer(3, -1, 0, -1, 2);
    run_xfer(2, -1, 0, -1, 0);

    // Randomized lengths, data and stall windows
    rnd_data = 1'b1;
    for (int n = 0; n < 10; n++) begin
      L  = int'($urandom_range(1, 12));
      sl = int'($urandom_range(0, 4));
      if (sl == 4) sl = -1;
      su = int'($urandom_range(0, 10));
      launch(L);
      run_xfer(L, sl, su, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
